// File: rtl/safe_code_check.sv
// Combination-lock code checker: assembles a 6-digit entry from the digit FSM,
// then stores it (SET) or compares it (CHECK) with one-cycle result pulses and failure lockout.
// Optional master-code override is compiled in with `define SAFE_MASTER_CODE_EN.
module safe_code_check #(
    parameter logic [23:0] RESET_CODE     = 24'h123456,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 50_000_000
`ifdef SAFE_MASTER_CODE_EN
    ,
    parameter logic [23:0] MASTER_CODE    = 24'h999999
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] main_state,
    input  logic [3:0] digit_state,
    input  logic       valid,
    input  logic [3:0] digit_in,
    output logic [2:0] entry_count,
    output logic       code_saved,
    output logic       set_error,
    output logic       match,
    output logic       mismatch,
    output logic [3:0] fail_count,
    output logic       lockout
);

    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_dig [6];
    logic            r_bad;
    logic            r_mode_set;
    logic [23:0]     r_code;
    logic [TW-1:0]   r_timer;

    logic            w_mode_entry;
    logic            w_mode_idle;
    logic            w_capture;
    logic [2:0]      w_slot;
    logic [23:0]     w_entry;
    logic            w_eq;
    logic [3:0]      w_fail_next;
    logic            w_master;

    assign w_mode_entry = (main_state == 3'b001) || (main_state == 3'b101);
    assign w_mode_idle  = (main_state == 3'b000) || (main_state == 3'b100);
    // Odd codes 1..B are "digit awaiting confirm"; slot is simply the upper three bits.
    assign w_capture    = digit_state[0] && (digit_state <= 4'hB) && valid;
    assign w_slot       = digit_state[3:1];
    assign w_entry      = {r_dig[0], r_dig[1], r_dig[2], r_dig[3], r_dig[4], r_dig[5]};
    assign w_eq         = (w_entry == r_code) && !r_bad;
    assign w_fail_next  = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;
`ifdef SAFE_MASTER_CODE_EN
    assign w_master     = (w_entry == MASTER_CODE) && !r_bad;
`else
    assign w_master     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            for (int k = 0; k < 6; k++) r_dig[k] <= 4'd0;
            r_bad       <= 1'b0;
            r_mode_set  <= 1'b0;
            r_code      <= RESET_CODE;
            r_timer     <= '0;
            entry_count <= 3'd0;
            code_saved  <= 1'b0;
            set_error   <= 1'b0;
            match       <= 1'b0;
            mismatch    <= 1'b0;
            fail_count  <= 4'd0;
            lockout     <= 1'b0;
        end else begin
            code_saved <= 1'b0;
            set_error  <= 1'b0;
            match      <= 1'b0;
            mismatch   <= 1'b0;

            // Lockout timer runs independently of the entry FSM; evaluation below may override it.
            if (lockout) begin
                if (r_timer == '0) begin
                    lockout    <= 1'b0;
                    fail_count <= 4'd0;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    for (int k = 0; k < 6; k++) r_dig[k] <= 4'd0;
                    r_bad       <= 1'b0;
                    entry_count <= 3'd0;
                    if (w_mode_entry && digit_state == 4'hC) begin
                        r_state    <= S_CAPTURE;
                        r_mode_set <= (main_state == 3'b001);
                    end
                end
                S_CAPTURE: begin
                    if (w_mode_idle) begin
                        r_state     <= S_IDLE;
                        entry_count <= 3'd0;
                        r_bad       <= 1'b0;
                    end else if (digit_state == 4'hD) begin
                        // Result is registered here so the pulse lands in the cycle after END.
                        r_state <= S_EVAL;
                        if (r_mode_set) begin
                            if (!r_bad && !lockout) begin
                                code_saved <= 1'b1;
                                fail_count <= 4'd0;
                            end else begin
                                set_error <= 1'b1;
                            end
                        end else if (w_master) begin
                            match      <= 1'b1;
                            lockout    <= 1'b0;
                            r_timer    <= '0;
                            fail_count <= 4'd0;
                        end else if (lockout) begin
                            mismatch <= 1'b1;
                        end else if (w_eq) begin
                            match      <= 1'b1;
                            fail_count <= 4'd0;
                        end else begin
                            mismatch   <= 1'b1;
                            fail_count <= w_fail_next;
                            if (w_fail_next >= 4'(MAX_FAILS)) begin
                                lockout <= 1'b1;
                                r_timer <= TW'(LOCKOUT_CYCLES - 1);
                            end
                        end
                    end else if (w_capture) begin
                        r_dig[w_slot] <= digit_in;
                        entry_count   <= w_slot + 3'd1;
                        if (digit_in > 4'd9) r_bad <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (code_saved) r_code <= w_entry;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (w_mode_idle) begin
                        r_state     <= S_IDLE;
                        entry_count <= 3'd0;
                        r_bad       <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
